hamming_enc_seq: RTL and testbench

HAMMING_ENC_SEQ -- requirements
Module: hamming_enc_seq

---
 rtl/hamming_pkg.sv | 17 +
 rtl/hamming_enc.sv | 19 +
 rtl/hamming_enc_seq.sv | 109 ++++++++++
 tb/tb_hamming_enc_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and default geometry for the Hamming(16,11) encoder/decoder pair.
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_HI = 3'd3,
    WR_LO = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int NUM_MSG_DEF  = 15;
  localparam int SRC_BASE_DEF = 0;
  localparam int DST_BASE_DEF = 30;

endpackage

// File: rtl/hamming_enc.sv
// Combinational SECDED Hamming(16,11) encoder; codeword = {d11..d5,p8, d4..d2,p4,d1,p2,p1,p0}.
module hamming_enc (
  input  logic [11:1] d,
  output logic [15:0] cw
);

  logic p8, p4, p2, p1, p0;

  always_comb begin
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    // Overall parity covers data and all check bits for double-error detection.
    p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
    cw = {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
  end

endmodule

// File: rtl/hamming_enc_seq.sv
// Sequencer that reads NUM_MSG 11-bit messages from byte memory, encodes each and writes the 16-bit codewords back.
module hamming_enc_seq
  import hamming_pkg::*;
#(
  parameter int NUM_MSG  = NUM_MSG_DEF,
  parameter int SRC_BASE = SRC_BASE_DEF,
  parameter int DST_BASE = DST_BASE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data,
  input  logic [7:0] mem_rd_data
);

  localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_MSG - 1);

  state_t        state_reg, state_next;
  logic [IW-1:0] i_reg;
  logic [11:1]   d_reg;
  logic          done_reg;
  logic [15:0]   cw;
  logic [7:0]    offs, src_lo, dst_lo;
  logic          start_ok;

  assign start_ok = start && (state_reg == IDLE || state_reg == DONE);
  // Byte offset 2*i, all address math wraps at 8 bits.
  assign offs     = 8'({i_reg, 1'b0});
  assign src_lo   = 8'(SRC_BASE) + offs;
  assign dst_lo   = 8'(DST_BASE) + offs;
  assign done     = done_reg;

  hamming_enc u_enc (
    .d  (d_reg),
    .cw (cw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: if (start) state_next = RD_LO;
      RD_LO:      state_next = RD_HI;
      RD_HI:      state_next = WR_HI;
      WR_HI:      state_next = WR_LO;
      WR_LO:      state_next = (i_reg != LAST) ? RD_LO : DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = 8'd0;
    mem_wr_data = 8'd0;
    case (state_reg)
      RD_LO: begin
        busy     = 1'b1;
        mem_addr = src_lo;
      end
      RD_HI: begin
        busy     = 1'b1;
        mem_addr = src_lo + 8'd1;
      end
      WR_HI: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = dst_lo + 8'd1;
        mem_wr_data = cw[15:8];
      end
      WR_LO: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_addr    = dst_lo;
        mem_wr_data = cw[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_reg    <= '0;
      d_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      if (start_ok) begin
        i_reg    <= '0;
        done_reg <= 1'b0;
      end else begin
        // done rises one cycle after entering DONE and holds until the next accepted start.
        if (state_reg == DONE) done_reg <= 1'b1;
        if (state_reg == WR_LO && i_reg != LAST) i_reg <= i_reg + IW'(1);
      end
      if (state_reg == RD_LO) d_reg[8:1]  <= mem_rd_data;
      if (state_reg == RD_HI) d_reg[11:9] <= mem_rd_data[2:0];
    end
  end

endmodule

// File: tb/tb_hamming_enc_seq.sv
// Self-checking bench: byte memory model plus a mask-based parity reference for the encoder sequencer.
module tb_hamming_enc_seq;

  localparam int NMSG = 15;
  localparam int SRC  = 0;
  localparam int DST  = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       done, busy, mem_wr_en;
  logic [7:0] mem_addr, mem_wr_data, mem_rd_data;

  logic [7:0]  mem [256];
  logic [10:0] msgs [NMSG];
  logic [4:0]  junk [NMSG];
  int          wr_count = 0;
  int          errors = 0;
  int          checks = 0;

  hamming_enc_seq #(.NUM_MSG(NMSG), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .done       (done),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  initial forever #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
    end
  end

  // Reference: each parity is the even parity of the data bits selected by a mask (bit k of dv is d_k).
  function automatic logic [15:0] ref_enc(input logic [10:0] m);
    logic [11:0] dv;
    logic p8, p4, p2, p1, p0;
    dv = {m, 1'b0};
    p8 = 1'($countones(dv & 12'hFE0) % 2);
    p4 = 1'($countones(dv & 12'hF1C) % 2);
    p2 = 1'($countones(dv & 12'hCDA) % 2);
    p1 = 1'($countones(dv & 12'hAB6) % 2);
    p0 = 1'(($countones(dv) + p8 + p4 + p2 + p1) % 2);
    return {dv[11:5], p8, dv[4:2], p4, dv[1], p2, p1, p0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_src();
    for (int k = 0; k < NMSG; k++) begin
      mem[SRC + 2*k]     <= msgs[k][7:0];
      mem[SRC + 2*k + 1] <= {junk[k], msgs[k][10:8]};
      mem[DST + 2*k]     <= 8'hA5;
      mem[DST + 2*k + 1] <= 8'hA5;
    end
    #0;
  endtask

  task automatic randomize_msgs();
    for (int k = 0; k < NMSG; k++) begin
      msgs[k] = 11'($urandom);
      junk[k] = 5'($urandom);
    end
  endtask

  task automatic check_mem(input int n);
    logic [15:0] cw;
    for (int k = 0; k < n; k++) begin
      cw = ref_enc(msgs[k]);
      $display("msg %0d: d=%03h -> hi=%02h lo=%02h (ref %02h/%02h)", k, msgs[k],
               mem[DST + 2*k + 1], mem[DST + 2*k], cw[15:8], cw[7:0]);
      chk($sformatf("dst_hi[%0d]", k), {8'h00, mem[DST + 2*k + 1]}, {8'h00, cw[15:8]});
      chk($sformatf("dst_lo[%0d]", k), {8'h00, mem[DST + 2*k]},     {8'h00, cw[7:0]});
    end
  endtask

  // Caller is positioned 1 time unit after an edge; the next edge is edge 0.
  task automatic run_full(input int pulse_edge);
    int wr0;
    wr0   = wr_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", {15'd0, busy}, 16'd1);
    chk("accept_done_clear", {15'd0, done}, 16'd0);
    for (int e = 1; e <= 61; e++) begin
      if (e == pulse_edge) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (e == 59) chk("busy_e59", {15'd0, busy}, 16'd1);
      if (e == 60) begin
        chk("done_e60", {15'd0, done}, 16'd0);
        chk("busy_e60", {15'd0, busy}, 16'd0);
      end
      if (e == 61) chk("done_e61", {15'd0, done}, 16'd1);
    end
    chk("wr_strobes", 16'(wr_count - wr0), 16'd30);
    chk("idle_addr", {8'h00, mem_addr}, 16'h0000);
    check_mem(NMSG);
  endtask

  initial begin
    int wr0;
    for (int a = 0; a < 256; a++) mem[a] <= 8'h00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_wr_en", {15'd0, mem_wr_en}, 16'd0);
    chk("rst_addr", {8'h00, mem_addr}, 16'h0000);
    chk("rst_wdata", {8'h00, mem_wr_data}, 16'h0000);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", {15'd0, busy}, 16'd0);

    // All-zero messages
    for (int k = 0; k < NMSG; k++) begin msgs[k] = 11'h000; junk[k] = 5'h00; end
    load_src();
    run_full(0);

    // Directed corners plus random fill
    randomize_msgs();
    msgs[0] = 11'h7FF; junk[0] = 5'h00;
    msgs[1] = 11'h001; junk[1] = 5'h00;
    msgs[2] = 11'h001; junk[2] = 5'h1F;
    load_src();
    run_full(0);

    // Fully random run
    randomize_msgs();
    load_src();
    run_full(0);

    // Reset at edge 20 aborts the run
    randomize_msgs();
    load_src();
    wr0   = wr_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_wr_en", {15'd0, mem_wr_en}, 16'd0);
    chk("abort_addr", {8'h00, mem_addr}, 16'h0000);
    chk("abort_writes", 16'(wr_count - wr0), 16'd10);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_more_writes", 16'(wr_count - wr0), 16'd10);
    check_mem(5);
    chk("abort_untouched_hi5", {8'h00, mem[DST + 11]}, 16'h00A5);
    chk("abort_untouched_lo5", {8'h00, mem[DST + 10]}, 16'h00A5);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_abort_idle_done", {15'd0, done}, 16'd0);
    load_src();
    run_full(0);

    // start pulse mid-run is ignored
    randomize_msgs();
    load_src();
    run_full(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
